// File: rtl/fu_issue_arbiter.sv
// Issue arbiter: picks one ready reservation-station entry per cycle for each of ALU0, ALU1 and the memory unit.
// Macro FU_ISSUE_RR_EN selects per-FU round-robin priority; when undefined, the lowest index wins.
module fu_issue_arbiter #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ENTRIES-1:0]   req_valid,
    input  logic [2*ENTRIES-1:0] req_fu,
    input  logic                 mem_done,
    input  logic                 flush,
    output logic [2:0]           grant_valid,
    output logic [4:0]           grant_idx0,
    output logic [4:0]           grant_idx1,
    output logic [4:0]           grant_idx2,
    output logic [2:0]           func_units
);

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    typedef enum logic {
        FU_IDLE,
        FU_BUSY
    } fu_state_t;

    fu_state_t               r_state [3];
    logic [1:0][3:0]         r_cnt;
    logic [ENTRIES-1:0]      r_mask;
    logic [2:0]              r_grant_valid;
    logic [2:0][4:0]         r_grant_idx;

    logic [2:0][ENTRIES-1:0] w_elig;
    logic [2:0]              w_sel_vld;
    logic [2:0][4:0]         w_sel_idx;
    logic [2:0]              w_issue;
    logic [ENTRIES-1:0]      w_issue_mask;

    // An entry granted last cycle is hidden for one cycle so the requester can retire it.
    always_comb begin
        w_elig = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                w_elig[k][i] = req_valid[i] && (req_fu[2*i +: 2] == 2'(k)) && !r_mask[i];
            end
        end
    end

`ifdef FU_ISSUE_RR_EN
    logic [2:0][4:0] r_ptr;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_sel_vld = '0;
        w_sel_idx = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned off = 0; off < ENTRIES; off++) begin
                idx = (32'(r_ptr[k]) + off) % ENTRIES;
                if (!w_sel_vld[k] && w_elig[k][idx]) begin
                    w_sel_vld[k] = 1'b1;
                    w_sel_idx[k] = 5'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (w_issue[k]) begin
                    r_ptr[k] <= 5'((32'(w_sel_idx[k]) + 1) % ENTRIES);
                end
            end
        end
    end
`else
    always_comb begin
        w_sel_vld = '0;
        w_sel_idx = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (!w_sel_vld[k] && w_elig[k][i]) begin
                    w_sel_vld[k] = 1'b1;
                    w_sel_idx[k] = 5'(i);
                end
            end
        end
    end
`endif

    always_comb begin
        w_issue      = '0;
        w_issue_mask = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            w_issue[k] = (r_state[k] == FU_IDLE) && w_sel_vld[k] && !flush;
            if (w_issue[k]) begin
                w_issue_mask[w_sel_idx[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_valid <= '0;
            r_grant_idx   <= '0;
            r_mask        <= '0;
            r_cnt         <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                r_state[k] <= FU_IDLE;
            end
        end else begin
            r_grant_valid <= w_issue;
            r_mask        <= w_issue_mask;
            for (int unsigned k = 0; k < 3; k++) begin
                if (w_issue[k]) begin
                    r_grant_idx[k] <= w_sel_idx[k];
                end
            end

            for (int unsigned k = 0; k < 2; k++) begin
                if (flush) begin
                    r_state[k] <= FU_IDLE;
                    r_cnt[k]   <= '0;
                end else if (r_state[k] == FU_IDLE) begin
                    if (w_issue[k]) begin
                        r_cnt[k]   <= LAT_M1;
                        r_state[k] <= (ALU_LAT > 1) ? FU_BUSY : FU_IDLE;
                    end
                end else if (r_cnt[k] == '0) begin
                    r_state[k] <= FU_IDLE;
                end else begin
                    r_cnt[k] <= r_cnt[k] - 4'd1;
                end
            end

            // An outstanding memory access survives flush; only mem_done frees the unit.
            if (r_state[2] == FU_IDLE) begin
                if (w_issue[2]) begin
                    r_state[2] <= FU_BUSY;
                end
            end else if (mem_done) begin
                r_state[2] <= FU_IDLE;
            end
        end
    end

    always_comb begin
        func_units = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            func_units[k] = (r_state[k] == FU_IDLE);
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_idx0  = r_grant_idx[0];
    assign grant_idx1  = r_grant_idx[1];
    assign grant_idx2  = r_grant_idx[2];

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Bench for fu_issue_arbiter: vector table with a scoreboard queue, two instances (ALU_LAT=1 and ALU_LAT=3).
module tb_fu_issue_arbiter;

    localparam logic [63:0] RF_INV = '1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req_valid = '0;
    logic [63:0] req_fu = RF_INV;
    logic        mem_done = 1'b0;
    logic        flush = 1'b0;

    logic [2:0]  gv1, fu1, gv3, fu3;
    logic [4:0]  a0, a1, a2, b0, b1, b2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fu_issue_arbiter #(.ENTRIES(32), .ALU_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_fu(req_fu),
        .mem_done(mem_done), .flush(flush), .grant_valid(gv1),
        .grant_idx0(a0), .grant_idx1(a1), .grant_idx2(a2), .func_units(fu1)
    );

    fu_issue_arbiter #(.ENTRIES(32), .ALU_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_fu(req_fu),
        .mem_done(mem_done), .flush(flush), .grant_valid(gv3),
        .grant_idx0(b0), .grant_idx1(b1), .grant_idx2(b2), .func_units(fu3)
    );

    typedef struct {
        bit          d;
        bit          rst;
        logic [31:0] rv;
        logic [63:0] rf;
        bit          md;
        bit          fl;
        logic [2:0]  gv;
        logic [4:0]  g0, g1, g2;
        logic [2:0]  fu;
        bit          all;
    } vec_t;

    typedef struct {
        int          id;
        bit          d;
        logic [2:0]  gv;
        logic [4:0]  g0, g1, g2;
        logic [2:0]  fu;
        bit          all;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic logic [63:0] setfu(input logic [63:0] base, input int e, input logic [1:0] f);
        logic [63:0] r;
        r = base;
        r[2*e +: 2] = f;
        return r;
    endfunction

    task automatic add(input bit d, input bit rst, input logic [31:0] rv, input logic [63:0] rf,
                       input bit md, input bit fl, input logic [2:0] gv, input int g0, input int g1,
                       input int g2, input logic [2:0] fu, input bit all);
        vec_t v;
        v.d = d; v.rst = rst; v.rv = rv; v.rf = rf; v.md = md; v.fl = fl;
        v.gv = gv; v.g0 = 5'(g0); v.g1 = 5'(g1); v.g2 = 5'(g2); v.fu = fu; v.all = all;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] rf_b, rf_c, rf_d, rf_e, rf_f, rf_g;
        int          d_exp [5];
        exp_t        e;
        logic [2:0]  agv, afu;
        logic [4:0]  ai0, ai1, ai2;
        int          dly;

        rf_b = setfu(setfu(RF_INV, 4, 2'd0), 9, 2'd0);
        rf_c = setfu(setfu(RF_INV, 0, 2'd1), 31, 2'd1);
        rf_d = setfu(setfu(setfu(RF_INV, 1, 2'd0), 2, 2'd0), 3, 2'd0);
        rf_e = setfu(RF_INV, 2, 2'd2);
        rf_f = setfu(setfu(setfu(RF_INV, 1, 2'd0), 3, 2'd1), 6, 2'd2);
        rf_g = setfu(setfu(setfu(setfu(setfu(RF_INV, 1, 2'd0), 3, 2'd1), 5, 2'd2), 7, 2'd3), 2, 2'd0);
`ifdef FU_ISSUE_RR_EN
        d_exp = '{1, 2, 3, 1, 2};
`else
        d_exp = '{1, 2, 1, 2, 1};
`endif

        // Reset, then idle for five cycles
        add(0, 1, 0, RF_INV, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);
        add(0, 1, 0, RF_INV, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);
        for (int i = 0; i < 5; i++) add(0, 0, 0, RF_INV, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);

        // ALU_LAT=3: entries 4 and 9 on FU0
        add(1, 1, 0, RF_INV, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);
        add(1, 0, 32'h210, rf_b, 0, 0, 3'b001, 4, 0, 0, 3'b110, 0);
        add(1, 0, 32'h200, rf_b, 0, 0, 3'b000, 4, 0, 0, 3'b110, 1);
        add(1, 0, 32'h200, rf_b, 0, 0, 3'b000, 0, 0, 0, 3'b110, 0);
        add(1, 0, 32'h200, rf_b, 0, 0, 3'b000, 0, 0, 0, 3'b111, 0);
        add(1, 0, 32'h200, rf_b, 0, 0, 3'b001, 9, 0, 0, 3'b110, 0);
        add(1, 0, 0, rf_b, 0, 0, 3'b000, 0, 0, 0, 3'b110, 0);
        add(1, 0, 0, rf_b, 0, 0, 3'b000, 0, 0, 0, 3'b110, 0);
        add(1, 0, 0, rf_b, 0, 0, 3'b000, 0, 0, 0, 3'b111, 0);

        // Entries 0 and 31 on FU1, ALU_LAT=1: alternate through the grant mask
        add(0, 1, 0, RF_INV, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);
        add(0, 0, 32'h8000_0001, rf_c, 0, 0, 3'b010, 0, 0, 0, 3'b111, 0);
        add(0, 0, 32'h8000_0001, rf_c, 0, 0, 3'b010, 0, 31, 0, 3'b111, 0);
        add(0, 0, 32'h8000_0001, rf_c, 0, 0, 3'b010, 0, 0, 0, 3'b111, 0);
        add(0, 0, 32'h8000_0001, rf_c, 0, 0, 3'b010, 0, 31, 0, 3'b111, 0);
        add(0, 0, 0, rf_c, 0, 0, 3'b000, 0, 31, 0, 3'b111, 1);

        // Entries 1,2,3 on FU0: priority rule visible in the grant order
        add(0, 1, 0, RF_INV, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);
        for (int i = 0; i < 5; i++) add(0, 0, 32'h0E, rf_d, 0, 0, 3'b001, d_exp[i], 0, 0, 3'b111, 0);
        add(0, 0, 0, rf_d, 0, 0, 3'b000, d_exp[4], 0, 0, 3'b111, 1);

        // Memory unit: long access, no re-grant while busy, idle mem_done ignored
        add(0, 1, 0, RF_INV, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);
        add(0, 0, 32'h4, rf_e, 0, 0, 3'b100, 0, 0, 2, 3'b011, 0);
        for (int i = 0; i < 9; i++) add(0, 0, 32'h4, rf_e, 0, 0, 3'b000, 0, 0, 2, 3'b011, 1);
        add(0, 0, 32'h4, rf_e, 1, 0, 3'b000, 0, 0, 0, 3'b111, 0);
        add(0, 0, 32'h4, rf_e, 0, 0, 3'b100, 0, 0, 2, 3'b011, 0);
        add(0, 0, 0, rf_e, 0, 0, 3'b000, 0, 0, 0, 3'b011, 0);
        add(0, 0, 0, rf_e, 1, 0, 3'b000, 0, 0, 0, 3'b111, 0);
        add(0, 0, 0, rf_e, 1, 0, 3'b000, 0, 0, 0, 3'b111, 0);
        add(0, 0, 32'h4, rf_e, 1, 0, 3'b100, 0, 0, 2, 3'b011, 0);
        add(0, 0, 0, rf_e, 1, 0, 3'b000, 0, 0, 0, 3'b111, 0);

        // Flush with FU2 outstanding (ALU_LAT=3), flush+mem_done, reset mid-busy
        add(1, 1, 0, RF_INV, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);
        add(1, 0, 32'h40, rf_f, 0, 0, 3'b100, 0, 0, 6, 3'b011, 0);
        add(1, 0, 32'h0A, rf_f, 0, 1, 3'b000, 0, 0, 0, 3'b011, 0);
        add(1, 0, 32'h0A, rf_f, 0, 0, 3'b011, 1, 3, 0, 3'b000, 0);
        add(1, 0, 0, rf_f, 0, 1, 3'b000, 0, 0, 0, 3'b011, 0);
        add(1, 0, 32'h0A, rf_f, 0, 0, 3'b011, 1, 3, 0, 3'b000, 0);
        add(1, 0, 0, rf_f, 1, 1, 3'b000, 0, 0, 0, 3'b111, 0);
        add(1, 0, 32'h42, rf_f, 0, 0, 3'b101, 1, 0, 6, 3'b010, 0);
        add(1, 1, 32'h4A, rf_f, 1, 1, 3'b000, 0, 0, 0, 3'b111, 1);
        add(1, 0, 0, rf_f, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);

        // Three grants in one cycle; invalid target never granted
        add(0, 1, 0, RF_INV, 0, 0, 3'b000, 0, 0, 0, 3'b111, 1);
        add(0, 0, 32'hAA, rf_g, 0, 0, 3'b111, 1, 3, 5, 3'b011, 0);
        add(0, 0, 32'h80, rf_g, 1, 0, 3'b000, 0, 0, 0, 3'b111, 0);
        add(0, 0, 32'h80, rf_g, 0, 0, 3'b000, 0, 0, 0, 3'b111, 0);
        add(0, 0, 32'h05, rf_g, 0, 0, 3'b001, 2, 0, 0, 3'b111, 0);

        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            reset     = vecs[v].rst;
            req_valid = vecs[v].rv;
            req_fu    = vecs[v].rf;
            mem_done  = vecs[v].md;
            flush     = vecs[v].fl;
            sb.push_back('{v, vecs[v].d, vecs[v].gv, vecs[v].g0, vecs[v].g1, vecs[v].g2,
                           vecs[v].fu, vecs[v].all});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            agv = e.d ? gv3 : gv1;
            afu = e.d ? fu3 : fu1;
            ai0 = e.d ? b0 : a0;
            ai1 = e.d ? b1 : a1;
            ai2 = e.d ? b2 : a2;
            chk($sformatf("v%0d.grant_valid", e.id), 32'(agv), 32'(e.gv));
            chk($sformatf("v%0d.func_units", e.id), 32'(afu), 32'(e.fu));
            if (e.gv[0] || e.all) chk($sformatf("v%0d.grant_idx0", e.id), 32'(ai0), 32'(e.g0));
            if (e.gv[1] || e.all) chk($sformatf("v%0d.grant_idx1", e.id), 32'(ai1), 32'(e.g1));
            if (e.gv[2] || e.all) chk($sformatf("v%0d.grant_idx2", e.id), 32'(ai2), 32'(e.g2));
        end

        // Memory access of random length: FU2 must stay busy exactly until mem_done
        @(negedge clk);
        reset = 1'b1; req_valid = '0; mem_done = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b0; req_valid = 32'h400; req_fu = setfu(RF_INV, 10, 2'd2);
        @(posedge clk);
        #1;
        chk("mem.grant_valid", 32'(gv1), 32'h4);
        chk("mem.grant_idx2", 32'(a2), 32'd10);
        dly = $urandom_range(2, 8);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_valid = '0;
            mem_done  = (c == dly);
            @(posedge clk);
            #1;
            chk($sformatf("mem.c%0d.fu2", c), 32'(fu1[2]), (c >= dly) ? 32'd1 : 32'd0);
            chk($sformatf("mem.c%0d.grant_valid", c), 32'(gv1), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
